fetch_unit: RTL

Instruction fetch stage for the RV32I core. Holds the PC and issues requests to instruction memory over a req/gnt/rvalid handshake. Presents the fetched word and its PC to decode, with opcode/fun3/fun7 pre-split for the control unit. Accepts PC redirects (Jal, Jalr, taken Branch) from execute.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/pc_next_sel.sv | 34 +++
 rtl/fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32I fetch stage: FSM encoding, NOP word,
// instruction field positions and the sequential PC increment.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int FUN3_LSB   = 12;
    localparam int FUN3_MSB   = 14;
    localparam int FUN7_BIT   = 30;

    localparam int PC_INC = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage: redirect beats sequential advance.
// FETCH_MISALIGN_TRAP_EN keeps misaligned targets and flags them; otherwise targets are word-aligned.
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    input  logic            advance,
    output logic [XLEN-1:0] pc_next,
    output logic            misaligned
);

    logic [XLEN-1:0] target_eff;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_eff = target;
    assign misaligned = redirect && (target[1:0] != 2'b00);
`else
    assign target_eff = target & ~XLEN'(3);
    assign misaligned = 1'b0;
`endif

    always_comb begin
        pc_next = pc;
        if (redirect)
            pc_next = target_eff;
        else if (advance)
            pc_next = pc + XLEN'(PC_INC);   // wraps modulo 2^XLEN
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: req/gnt/rvalid memory handshake, redirect handling, decode hand-off.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN (see pc_next_sel).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            dec_ready,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc_out,
    output logic [6:0]      opcode,
    output logic [2:0]      fun3,
    output logic            fun7,
    output logic            fetch_misalign
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next, pc_out_next;
    logic [31:0]     instr_next;
    logic            kill, kill_next, valid_next, misalign_next;
    logic            redir, advance, misaligned;

    // Redirects are ignored during the post-reset IDLE cycle.
    assign redir   = redirect_valid && (state != IDLE);
    assign advance = (state == HOLD) && dec_ready && !redir;

    pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
        .pc         (pc),
        .redirect   (redir),
        .target     (redirect_target),
        .advance    (advance),
        .pc_next    (pc_next),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        kill_next     = kill;
        instr_next    = instr;
        pc_out_next   = pc_out;
        valid_next    = instr_valid;
        misalign_next = fetch_misalign;
        imem_req      = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                imem_req = 1'b1;
                // A grant alongside a redirect is for the old PC and must be dropped.
                if (imem_gnt) begin
                    state_next = WAIT;
                    kill_next  = redir;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    kill_next = 1'b0;
                    if (redir || kill) begin
                        state_next = REQ;
                    end else begin
                        instr_next  = imem_rdata;
                        pc_out_next = pc;
                        valid_next  = 1'b1;
                        state_next  = HOLD;
                    end
                end else if (redir) begin
                    kill_next = 1'b1;
                end
            end
            HOLD: begin
                if (imem_rvalid)
                    kill_next = 1'b0;
                if (redir || dec_ready) begin
                    valid_next    = 1'b0;
                    instr_next    = NOP;
                    misalign_next = 1'b0;
                    state_next    = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        // Misaligned target: present a trap bubble instead of fetching.
        if (redir && misaligned) begin
            state_next    = HOLD;
            valid_next    = 1'b1;
            misalign_next = 1'b1;
            instr_next    = NOP;
            pc_out_next   = pc_next;
            if (state == REQ)
                kill_next = imem_gnt;
            else if (state == WAIT)
                kill_next = !imem_rvalid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc             <= XLEN'(RESET_PC);
            pc_out         <= XLEN'(RESET_PC);
            instr          <= NOP;
            instr_valid    <= 1'b0;
            kill           <= 1'b0;
            fetch_misalign <= 1'b0;
        end else begin
            pc             <= pc_next;
            pc_out         <= pc_out_next;
            instr          <= instr_next;
            instr_valid    <= valid_next;
            kill           <= kill_next;
            fetch_misalign <= misalign_next;
        end
    end

    assign imem_addr = {pc[XLEN-1:2], 2'b00};
    assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
    assign fun3      = instr[FUN3_MSB:FUN3_LSB];
    assign fun7      = instr[FUN7_BIT];

endmodule
